// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: FSM state encoding and word defaults.
package spi_pkg;

  localparam int         SPI_WORD_W    = 8;
  localparam logic [7:0] SPI_IDLE_WORD = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, with a selectable reset value.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= {2{RST_VAL}};
    else         sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target, MSB first, oversampled by clk_25, with a one-word TX holding register.
// Define SPI_TARGET_STATUS_EN to build the sticky underrun/frame_err flags.
module spi_target
  import spi_pkg::*;
#(
  parameter int                DATA_W    = SPI_WORD_W,
  parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(SPI_IDLE_WORD)
) (
  input  logic              clk_25,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  input  logic              status_clr,
  output logic              underrun,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic sck_s, cs_n_s, mosi_s;
  logic sck_prev_q, cs_n_prev_q;

  // Reset values chosen so the post-reset pins never look like an edge
  spi_sync #(.RST_VAL(1'b0)) u_sync_sck  (.clk_i(clk_25), .rst_ni(rst_n), .d_i(spi_sck),  .q_o(sck_s));
  spi_sync #(.RST_VAL(1'b1)) u_sync_cs   (.clk_i(clk_25), .rst_ni(rst_n), .d_i(spi_cs_n), .q_o(cs_n_s));
  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk_i(clk_25), .rst_ni(rst_n), .d_i(spi_mosi), .q_o(mosi_s));

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      sck_prev_q  <= 1'b0;
      cs_n_prev_q <= 1'b1;
    end else begin
      sck_prev_q  <= sck_s;
      cs_n_prev_q <= cs_n_s;
    end
  end

  logic sck_rise, sck_fall, cs_fall, cs_rise;
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_n_s & cs_n_prev_q;
  assign cs_rise  = cs_n_s & ~cs_n_prev_q;

  spi_state_e        state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] tx_sr_q, rx_sr_q, hold_q, rx_data_q;
  logic              hold_full_q, rx_valid_q;

  logic              in_shift, reload, idle_load, mid_word, tx_push, word_end;
  logic [DATA_W-1:0] rx_word_d, reload_word_d;

  always_comb begin
    in_shift      = (state_q == ST_SHIFT);
    word_end      = (bit_cnt_q == CNT_W'(DATA_W));
    reload        = !cs_rise && ((state_q == ST_LOAD) || (in_shift && sck_fall && word_end));
    idle_load     = reload && !hold_full_q;
    reload_word_d = hold_full_q ? hold_q : IDLE_WORD;
    // A boundary (count 0 or DATA_W) is not mid-word; a loaded TX word is simply lost
    mid_word      = in_shift && cs_rise && (bit_cnt_q != '0) && !word_end;
    tx_push       = tx_valid && !hold_full_q;
    rx_word_d     = {rx_sr_q[DATA_W-2:0], mosi_s};
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;

      // Push and reload-from-full are exclusive, so a same-cycle push is never lost
      if (tx_push) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end else if (reload && hold_full_q) begin
        hold_full_q <= 1'b0;
      end

      if (reload)                           tx_sr_q <= reload_word_d;
      else if (in_shift && sck_fall && !cs_rise) tx_sr_q <= tx_sr_q << 1;

      if (cs_rise) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= '0;
        rx_sr_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: if (cs_fall) state_q <= ST_LOAD;
          ST_LOAD: state_q <= ST_SHIFT;
          ST_SHIFT: begin
            if (sck_rise) begin
              rx_sr_q   <= rx_word_d;
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                rx_data_q  <= rx_word_d;
                rx_valid_q <= 1'b1;
              end
            end else if (sck_fall && word_end) begin
              bit_cnt_q <= '0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign spi_miso = busy & tx_sr_q[DATA_W-1];
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = ~hold_full_q;

`ifdef SPI_TARGET_STATUS_EN
  logic underrun_q, frame_err_q;

  // Set wins over a simultaneous clear
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      underrun_q  <= idle_load | (underrun_q & ~status_clr);
      frame_err_q <= mid_word | (frame_err_q & ~status_clr);
    end
  end

  assign underrun  = underrun_q;
  assign frame_err = frame_err_q;
`else
  logic unused_status;
  assign unused_status = ^{status_clr, idle_load, mid_word};
  assign underrun      = 1'b0;
  assign frame_err     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: an SPI initiator at 5 MHz against a 25 MHz system clock.
module tb_spi_target;

`ifdef SPI_TARGET_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic       clk_25 = 1'b0, rst_n = 1'b0;
  logic       spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic       spi_miso, rx_valid, tx_ready, busy, underrun, frame_err;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, status_clr = 1'b0;

  int         errors = 0, checks = 0, rx_cnt = 0;
  logic [7:0] rx_last = 8'h00;

  spi_target dut (
    .clk_25(clk_25), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .status_clr(status_clr), .underrun(underrun), .frame_err(frame_err)
  );

  always #20 clk_25 = ~clk_25;

  always @(negedge clk_25) begin
    if (rx_valid === 1'b1) begin
      rx_cnt++;
      rx_last = rx_data;
    end
  end

  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk_25);
    while (tx_ready !== 1'b1 && n < 50) begin
      @(negedge clk_25);
      n++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready: tx_ready=%b expected 1", tx_ready);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk_25);
    tx_valid = 1'b0;
  endtask

  // SPI events are offset by 7 ns so they never coincide with a clk_25 edge
  task automatic cs_low();
    #7 spi_cs_n = 1'b0;
    #250;
  endtask

  task automatic cs_high();
    #200 spi_cs_n = 1'b1;
    #300;
  endtask

  // MISO is sampled late in the high phase, well after the synchronised update
  task automatic spi_word(input logic [7:0] mo, output logic [7:0] mi);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = mo[i];
      #100 spi_sck = 1'b1;
      #90  mi[i] = spi_miso;
      #10  spi_sck = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk_25) status_clr = 1'b1;
    @(negedge clk_25) status_clr = 1'b0;
  endtask

  task automatic test_reset();
    #55;
    checks += 7;
    if (tx_ready !== 1'b1)   begin errors++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (spi_miso !== 1'b0)   begin errors++; $display("FAIL rst_miso: got %b want 0", spi_miso); end
    if (rx_valid !== 1'b0)   begin errors++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
    if (rx_data !== 8'h00)   begin errors++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
    if (underrun !== 1'b0)   begin errors++; $display("FAIL rst_underrun: got %b want 0", underrun); end
    if (frame_err !== 1'b0)  begin errors++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
    #100 rst_n = 1'b1;
    repeat (10) @(negedge clk_25);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_no_false_edge: busy=%b want 0", busy); end
    if (rx_cnt != 0)   begin errors++; $display("FAIL rst_no_rx: pulses=%0d want 0", rx_cnt); end
  endtask

  task automatic test_basic();
    logic [7:0] mi;
    int n0;
    push(8'hA5);
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL basic_full: tx_ready=%b want 0", tx_ready); end
    n0 = rx_cnt;
    cs_low();
    checks += 2;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL basic_load_ready: tx_ready=%b want 1", tx_ready); end
    if (busy !== 1'b1)     begin errors++; $display("FAIL basic_busy: busy=%b want 1", busy); end
    spi_word(8'h3C, mi);
    cs_high();
    checks += 5;
    if (mi !== 8'hA5)       begin errors++; $display("FAIL basic_miso: got %h want a5", mi); end
    if (rx_cnt - n0 != 1)   begin errors++; $display("FAIL basic_pulses: got %0d want 1", rx_cnt - n0); end
    if (rx_last !== 8'h3C)  begin errors++; $display("FAIL basic_rx: got %h want 3c", rx_last); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL basic_idle: busy=%b want 0", busy); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_frame_err: got %b want 0", frame_err); end
  endtask

  task automatic test_underrun();
    logic [7:0] m0, m1, m2;
    int n0;
    pulse_clr();
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear: underrun=%b want 0", underrun); end
    push(8'h11);
    n0 = rx_cnt;
    cs_low();
    spi_word(8'h01, m0);
    spi_word(8'h02, m1);
    spi_word(8'h03, m2);
    cs_high();
    checks += 6;
    if (m0 !== 8'h11)          begin errors++; $display("FAIL ur_w0: got %h want 11", m0); end
    if (m1 !== 8'hFF)          begin errors++; $display("FAIL ur_w1: got %h want ff", m1); end
    if (m2 !== 8'hFF)          begin errors++; $display("FAIL ur_w2: got %h want ff", m2); end
    if (rx_cnt - n0 != 3)      begin errors++; $display("FAIL ur_pulses: got %0d want 3", rx_cnt - n0); end
    if (rx_last !== 8'h03)     begin errors++; $display("FAIL ur_rx: got %h want 03", rx_last); end
    if (underrun !== STATUS_EN) begin errors++; $display("FAIL ur_flag: got %b want %b", underrun, STATUS_EN); end
  endtask

  task automatic test_frame_err();
    logic [7:0] mi;
    int n0;
    pulse_clr();
    n0 = rx_cnt;
    cs_low();
    for (int i = 0; i < 5; i++) begin
      spi_mosi = 1'b1;
      #100 spi_sck = 1'b1;
      #100 spi_sck = 1'b0;
    end
    cs_high();
    checks += 3;
    if (rx_cnt != n0)            begin errors++; $display("FAIL fe_no_rx: pulses=%0d want 0", rx_cnt - n0); end
    if (frame_err !== STATUS_EN) begin errors++; $display("FAIL fe_flag: got %b want %b", frame_err, STATUS_EN); end
    if (busy !== 1'b0)           begin errors++; $display("FAIL fe_idle: busy=%b want 0", busy); end
    cs_low();
    spi_word(8'hC3, mi);
    cs_high();
    checks += 2;
    if (rx_cnt - n0 != 1)  begin errors++; $display("FAIL fe_next_pulses: got %0d want 1", rx_cnt - n0); end
    if (rx_last !== 8'hC3) begin errors++; $display("FAIL fe_next_rx: got %h want c3", rx_last); end
  endtask

  task automatic test_reload_push();
    logic [7:0] m0, m1;
    push(8'h5A);
    fork
      begin
        cs_low();
        spi_word(8'h7E, m0);
        spi_word(8'h81, m1);
        cs_high();
      end
      begin
        int n;
        n = 0;
        @(negedge clk_25);
        while (busy !== 1'b1 && n < 20) begin
          @(negedge clk_25);
          n++;
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rp_load_seen: busy=%b want 1", busy); end
        tx_data  = 8'h96;
        tx_valid = 1'b1;
        @(negedge clk_25);
        checks++;
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL rp_ready_after_load: got %b want 1", tx_ready); end
        @(negedge clk_25);
        checks++;
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL rp_ready_drop: got %b want 0", tx_ready); end
        tx_valid = 1'b0;
      end
    join
    checks += 3;
    if (m0 !== 8'h5A)      begin errors++; $display("FAIL rp_w0: got %h want 5a", m0); end
    if (m1 !== 8'h96)      begin errors++; $display("FAIL rp_w1: got %h want 96", m1); end
    if (rx_last !== 8'h81) begin errors++; $display("FAIL rp_rx: got %h want 81", rx_last); end
  endtask

  task automatic test_reset_mid();
    int n0;
    push(8'hAA);
    cs_low();
    push(8'hBB);
    #7;
    for (int i = 0; i < 3; i++) begin
      spi_mosi = 1'b1;
      #100 spi_sck = 1'b1;
      #100 spi_sck = 1'b0;
    end
    checks += 2;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL rm_pre_full: tx_ready=%b want 0", tx_ready); end
    if (busy !== 1'b1)     begin errors++; $display("FAIL rm_pre_busy: busy=%b want 1", busy); end
    n0 = rx_cnt;
    rst_n = 1'b0;
    #1;
    checks += 7;
    if (busy !== 1'b0)      begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
    if (spi_miso !== 1'b0)  begin errors++; $display("FAIL rm_miso: got %b want 0", spi_miso); end
    if (tx_ready !== 1'b1)  begin errors++; $display("FAIL rm_tx_ready: got %b want 1", tx_ready); end
    if (rx_data !== 8'h00)  begin errors++; $display("FAIL rm_rx_data: got %h want 00", rx_data); end
    if (rx_valid !== 1'b0)  begin errors++; $display("FAIL rm_rx_valid: got %b want 0", rx_valid); end
    if (underrun !== 1'b0)  begin errors++; $display("FAIL rm_underrun: got %b want 0", underrun); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL rm_frame_err: got %b want 0", frame_err); end
    #100 spi_cs_n = 1'b1;
    #100 rst_n = 1'b1;
    repeat (20) @(negedge clk_25);
    checks += 2;
    if (rx_cnt != n0)  begin errors++; $display("FAIL rm_no_rx: pulses=%0d want 0", rx_cnt - n0); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rm_idle: busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_frame_err();
    test_reload_push();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
- REQ-001 Parameter DATA_W, default 8: SPI word width in bits.
- REQ-002 Parameter IDLE_WORD, default 8'hFF: word shifted out on MISO when no TX word is queued.
- REQ-003 clk_25  in  1: system clock, all logic on the rising edge; SCK SHALL be at most clk_25/4.
- REQ-004 rst_n  in  1: asynchronous, active-low reset.
- REQ-005 spi_sck  in  1: SPI clock from the initiator, asynchronous to clk_25.
- REQ-006 spi_cs_n  in  1: chip select, active low, asynchronous.
- REQ-007 spi_mosi  in  1: serial data from the initiator.
- REQ-008 spi_miso  out  1: serial data to the initiator; the top level handles tristate.
- REQ-009 rx_data  out  DATA_W: last completely received word.
- REQ-010 rx_valid  out  1: single-cycle pulse marking a new rx_data.
- REQ-011 tx_data  in  DATA_W: next word to transmit.
- REQ-012 tx_valid  in  1: tx_data offered.
- REQ-013 tx_ready  out  1: TX holding register empty.
- REQ-014 busy  out  1: frame in progress (synchronised cs_n low).
- REQ-015 status_clr  in  1: clears the sticky status flags.
- REQ-016 underrun  out  1: sticky flag, IDLE_WORD was sent.
- REQ-017 frame_err  out  1: sticky flag, CS deasserted mid-word.

Function
- REQ-018 Protocol is SPI mode 0 (CPOL=0, CPHA=0), MSB first, for both directions.
- REQ-019 Synchronisation: spi_sck, spi_cs_n and spi_mosi each pass through 2 flops; edges are detected by comparing stage 2 with a third registered copy.
- REQ-020 States:
  - IDLE: CS high.
  - LOAD: one cycle after CS falls.
  - SHIFT: CS low.
- REQ-021 State transitions:
  - IDLE->LOAD on a synchronised CS falling edge.
  - LOAD->SHIFT unconditionally.
  - Any state->IDLE on a synchronised CS rising edge.
- REQ-022 LOAD and word reload:
  - Copy the holding register into the TX shift register if it is full, and mark the holding register empty.
  - Otherwise load IDLE_WORD.
- REQ-023 spi_miso = TX shift register MSB while busy, else 0.
- REQ-024 On an SCK rising edge in SHIFT: shift synchronised MOSI into the RX shift register LSB and increment a log2(DATA_W)+1-bit bit counter.
- REQ-025 On an SCK falling edge in SHIFT: shift the TX register left by one; if the bit counter equals DATA_W, reload per REQ-022 instead and clear the counter.
- REQ-026 When the DATA_W-th rising edge is detected, rx_data SHALL update and rx_valid SHALL pulse in the next clk_25 cycle; there is no backpressure and any unread word is overwritten.
- REQ-027 TX handshake:
  - A transfer occurs when tx_valid && tx_ready.
  - tx_ready = holding register empty.
  - A transfer in the same cycle as a reload SHALL NOT be lost; the reload takes the old word first, or IDLE_WORD if the register was empty.
- REQ-028 CS rising mid-word: discard the partial RX word, clear the counter, no rx_valid pulse; a word already loaded into the shift register counts as consumed.
- REQ-029 SCK edges while in IDLE or LOAD SHALL be ignored.

Reset
- REQ-030 On rst_n low, all of the following SHALL hold:
  - State is IDLE.
  - Counters are 0.
  - Shift registers are 0.
  - Holding register is empty (tx_ready=1).
  - rx_data=0, rx_valid=0, spi_miso=0, busy=0, underrun=0, frame_err=0.
  - Synchroniser flops are preset to sck=0 and cs_n=1, so no false edge occurs after reset.
- REQ-031 Reset asserted mid-frame SHALL abort the frame without an rx_valid pulse.

Configuration
- REQ-032 With macro SPI_TARGET_STATUS_EN defined:
  - underrun sets on every IDLE_WORD load.
  - frame_err sets on a mid-word CS rise.
  - Both flags clear when status_clr=1; a set and a clear in the same cycle leaves the flag set.
- REQ-033 Without SPI_TARGET_STATUS_EN, underrun and frame_err SHALL be tied to 0, status_clr SHALL be ignored, and no status flops SHALL be synthesised.

Structure
- REQ-034 Shared package spi_pkg SHALL hold:
  - the state enumeration;
  - the SPI_WORD_W default (8);
  - the SPI_IDLE_WORD default (8'hFF).
- REQ-035 Sub-module spi_sync (a 2-flop synchroniser with a reset-value parameter) SHALL be instantiated once per SPI input.

Verification
- REQ-036 Queue tx 8'hA5, initiator sends 8'h3C at 5 MHz -> miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C with one rx_valid pulse; tx_ready returns to 1 at LOAD.
- REQ-037 Three-word frame with only 8'h11 queued -> MISO sends 11,FF,FF; underrun=1 (macro on) or 0 (macro off); three rx_valid pulses.
- REQ-038 CS raised after 5 SCK rising edges -> no rx_valid; frame_err=1; the next full frame receives 8'hC3 correctly.
- REQ-039 tx_valid asserted on the exact reload cycle of word 1 -> word 2 carries the new data, nothing dropped, tx_ready deasserts one cycle later.
- REQ-040 rst_n pulsed low mid-frame -> all outputs at reset values within 0 cycles; no spurious rx_valid after release with cs_n high.
